// File: rtl/config_chain_loader.sv
// Bit-serial loader for a PE configuration chain.
// Optional readback verify recirculates the chain and compares the CRCs of the load and readback streams.
module config_chain_loader #(
   parameter int unsigned CHAIN_LEN = 64,
   parameter int unsigned WORD_W    = 32
) (
   input  logic              config_clk,
   input  logic              config_reset,
   input  logic              start,
   input  logic              verify_en,
   input  logic              wd_valid,
   output logic              wd_ready,
   input  logic [WORD_W-1:0] wd_data,
   input  logic              chain_tail,
   output logic              chain_out,
   output logic              chain_shift_en,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned BW       = $clog2(CHAIN_LEN + 1);
   localparam int unsigned CW       = $clog2(WORD_W + 1);
   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h1021;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

   // CRC-16-CCITT, one bit per call
   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
      crc_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC_POLY : 16'h0000);
   endfunction

   state_t            state;
   logic [WORD_W-1:0] word_reg;
   logic [CW-1:0]     bit_cnt;
   logic [BW-1:0]     bits_sent;
   logic              verify_q;
   logic [15:0]       crc_load;
   logic [15:0]       crc_ver;
   logic              out_q;

   logic [BW-1:0]     rem_c;
   logic [CW-1:0]     take_c;
   logic [WORD_W-1:0] word_shl_c;
   logic              last_bit_c;
   logic [15:0]       crc_load_nxt_c;
   logic [15:0]       crc_ver_nxt_c;

   assign rem_c          = BW'(CHAIN_LEN) - bits_sent;
   assign take_c         = (32'(rem_c) >= WORD_W) ? CW'(WORD_W) : CW'(rem_c);
   assign word_shl_c     = word_reg << 1;
   assign last_bit_c     = (bits_sent == BW'(CHAIN_LEN - 1));
   assign crc_load_nxt_c = crc_step(crc_load, word_reg[WORD_W-1]);
   assign crc_ver_nxt_c  = crc_step(crc_ver, chain_tail);

   // During verify the tail is fed straight back to the head so the pass is non-destructive
   assign chain_out = (state == S_VERIFY) ? chain_tail : out_q;

   always_ff @(posedge config_clk) begin
      if (!config_reset) begin
         state          <= S_IDLE;
         word_reg       <= '0;
         bit_cnt        <= '0;
         bits_sent      <= '0;
         verify_q       <= 1'b0;
         crc_load       <= CRC_INIT;
         crc_ver        <= CRC_INIT;
         out_q          <= 1'b0;
         wd_ready       <= 1'b0;
         chain_shift_en <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state          <= S_LOAD;
                  verify_q       <= verify_en;
                  error          <= 1'b0;
                  bits_sent      <= '0;
                  bit_cnt        <= '0;
                  word_reg       <= '0;
                  crc_load       <= CRC_INIT;
                  crc_ver        <= CRC_INIT;
                  out_q          <= 1'b0;
                  chain_shift_en <= 1'b0;
                  wd_ready       <= 1'b1;
                  busy           <= 1'b1;
               end
            end

            S_LOAD: begin
               if (bit_cnt == '0) begin
                  // bubble cycle: wait for the next word
                  if (wd_valid) begin
                     word_reg       <= wd_data;
                     bit_cnt        <= take_c;
                     wd_ready       <= 1'b0;
                     chain_shift_en <= 1'b1;
                     out_q          <= wd_data[WORD_W-1];
                  end
               end else begin
                  crc_load  <= crc_load_nxt_c;
                  word_reg  <= word_shl_c;
                  bit_cnt   <= bit_cnt - CW'(1);
                  bits_sent <= bits_sent + BW'(1);
                  if (last_bit_c) begin
                     bits_sent <= '0;
                     out_q     <= 1'b0;
                     if (verify_q) begin
                        state          <= S_VERIFY;
                        chain_shift_en <= 1'b1;
                     end else begin
                        state          <= S_DONE;
                        chain_shift_en <= 1'b0;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                     end
                  end else if (bit_cnt == CW'(1)) begin
                     chain_shift_en <= 1'b0;
                     out_q          <= 1'b0;
                     wd_ready       <= 1'b1;
                  end else begin
                     out_q <= word_shl_c[WORD_W-1];
                  end
               end
            end

            S_VERIFY: begin
               crc_ver   <= crc_ver_nxt_c;
               bits_sent <= bits_sent + BW'(1);
               if (last_bit_c) begin
                  state          <= S_DONE;
                  chain_shift_en <= 1'b0;
                  busy           <= 1'b0;
                  done           <= 1'b1;
                  error          <= (crc_ver_nxt_c != crc_load);
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
